// File: rtl/mag_bin_scanner_pkg.sv
// Shared types and constants for the bin scanner.
// Optional build macro MAG_SCAN_DC_EXCLUDE_EN is consumed by mag_bin_scanner.
package mag_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int PIPE_LAT    = 4;
  localparam int DEF_WIDTH   = 16;
  localparam int DEF_LUT_LOG = 8;

endpackage

// File: rtl/mag_bin_scanner_if.sv
// Bundles the control, bin RAM, magnitude-unit and result signals of the scanner.
// master = scanner side, slave = surrounding logic.
interface mag_bin_scanner_if #(
  parameter int WIDTH   = 16,
  parameter int BIN_LOG = 8,
  parameter int LUT_LOG = 8
);

  logic                      start;
  logic                      busy;
  logic                      done;
  logic                      bin_rd;
  logic        [BIN_LOG-1:0] bin_addr;
  logic signed [WIDTH-1:0]   bin_real;
  logic signed [WIDTH-1:0]   bin_cplx;
  logic                      mag_enable;
  logic        [LUT_LOG-1:0] mag_addr_real;
  logic        [LUT_LOG-1:0] mag_addr_cplx;
  logic        [WIDTH-1:0]   mag_in;
  logic                      out_valid;
  logic        [BIN_LOG-1:0] out_bin;
  logic        [WIDTH-1:0]   out_mag;
  logic        [BIN_LOG-1:0] peak_bin;
  logic        [WIDTH-1:0]   peak_mag;

  modport master (
    input  start, bin_real, bin_cplx, mag_in,
    output busy, done, bin_rd, bin_addr, mag_enable, mag_addr_real,
           mag_addr_cplx, out_valid, out_bin, out_mag, peak_bin, peak_mag
  );

  modport slave (
    output start, bin_real, bin_cplx, mag_in,
    input  busy, done, bin_rd, bin_addr, mag_enable, mag_addr_real,
           mag_addr_cplx, out_valid, out_bin, out_mag, peak_bin, peak_mag
  );

endinterface

// File: rtl/mag_bin_scanner_abs_quant.sv
// Saturating absolute value of one signed component, reduced to its top
// LUT_LOG magnitude bits for use as a magnitude-LUT index.
module mag_abs_quant
  import mag_scan_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LUT_LOG = DEF_LUT_LOG
) (
  input  logic signed [WIDTH-1:0]   i_x,
  output logic        [LUT_LOG-1:0] o_idx
);

  logic signed [WIDTH-1:0] w_neg;
  logic        [WIDTH-2:0] w_abs;

  assign w_neg = -i_x;

  // Only the most negative input still has its sign bit set after negation.
  always_comb begin
    w_abs = i_x[WIDTH-2:0];
    if (i_x[WIDTH-1]) begin
      w_abs = w_neg[WIDTH-1] ? '1 : w_neg[WIDTH-2:0];
    end
  end

  assign o_idx = LUT_LOG'(w_abs >> (WIDTH - 1 - LUT_LOG));

endmodule

// File: rtl/mag_bin_scanner.sv
// Walks the FFT bin RAM, feeds the external magnitude LUT unit and tracks the peak.
// Build macro MAG_SCAN_DC_EXCLUDE_EN: keep bin 0 out of peak tracking.
module mag_bin_scanner
  import mag_scan_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int N_BINS    = 256,
  parameter int BIN_LOG   = $clog2(N_BINS),
  parameter int LUT_DEPTH = 256,
  parameter int LUT_LOG   = $clog2(LUT_DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  mag_bin_scanner_if.master bus
);

  localparam logic [BIN_LOG-1:0] LAST_BIN = BIN_LOG'(N_BINS - 1);

  state_t               r_state;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_bin_rd;
  logic [BIN_LOG-1:0]   r_bin_addr;
  logic [PIPE_LAT-1:0]  r_vld;
  logic [BIN_LOG-1:0]   r_tag0, r_tag1, r_tag2, r_out_bin;
  logic [LUT_LOG-1:0]   r_idx_re, r_idx_im;
  logic [WIDTH-1:0]     r_out_mag, r_peak_mag;
  logic [BIN_LOG-1:0]   r_peak_bin;
  logic [LUT_LOG-1:0]   w_idx_re, w_idx_im;
  logic                 w_start_acc;
  logic                 w_peak_upd;

  mag_abs_quant #(.WIDTH(WIDTH), .LUT_LOG(LUT_LOG)) u_quant_re (
    .i_x   (bus.bin_real),
    .o_idx (w_idx_re)
  );

  mag_abs_quant #(.WIDTH(WIDTH), .LUT_LOG(LUT_LOG)) u_quant_im (
    .i_x   (bus.bin_cplx),
    .o_idx (w_idx_im)
  );

  assign w_start_acc = (r_state == IDLE) && bus.start;

`ifdef MAG_SCAN_DC_EXCLUDE_EN
  assign w_peak_upd = r_vld[PIPE_LAT-1] && (r_out_mag > r_peak_mag) && (r_out_bin != '0);
`else
  assign w_peak_upd = r_vld[PIPE_LAT-1] && (r_out_mag > r_peak_mag);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bin_rd   <= 1'b0;
      r_bin_addr <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state    <= RUN;
            r_busy     <= 1'b1;
            r_bin_rd   <= 1'b1;
            r_bin_addr <= '0;
          end
        end
        RUN: begin
          if (r_bin_addr == LAST_BIN) begin
            r_state    <= DRAIN;
            r_bin_rd   <= 1'b0;
            r_bin_addr <= '0;
          end else begin
            r_bin_addr <= r_bin_addr + BIN_LOG'(1);
          end
        end
        DRAIN: begin
          // Finish on the cycle the last bin's result is presented.
          if (r_vld[PIPE_LAT-1] && (r_out_bin == LAST_BIN)) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld     <= '0;
      r_tag0    <= '0;
      r_tag1    <= '0;
      r_tag2    <= '0;
      r_out_bin <= '0;
      r_idx_re  <= '0;
      r_idx_im  <= '0;
      r_out_mag <= '0;
    end else begin
      r_vld     <= {r_vld[PIPE_LAT-2:0], r_bin_rd};
      r_tag0    <= r_bin_addr;
      r_tag1    <= r_tag0;
      r_tag2    <= r_tag1;
      r_idx_re  <= r_vld[0] ? w_idx_re : '0;
      r_idx_im  <= r_vld[0] ? w_idx_im : '0;
      r_out_bin <= r_vld[2] ? r_tag2 : '0;
      r_out_mag <= r_vld[2] ? bus.mag_in : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || w_start_acc) begin
      r_peak_bin <= '0;
      r_peak_mag <= '0;
    end else if (w_peak_upd) begin
      r_peak_bin <= r_out_bin;
      r_peak_mag <= r_out_mag;
    end
  end

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.bin_rd        = r_bin_rd;
  assign bus.bin_addr      = r_bin_addr;
  assign bus.mag_enable    = r_vld[1];
  assign bus.mag_addr_real = r_idx_re;
  assign bus.mag_addr_cplx = r_idx_im;
  assign bus.out_valid     = r_vld[PIPE_LAT-1];
  assign bus.out_bin       = r_out_bin;
  assign bus.out_mag       = r_out_mag;
  assign bus.peak_bin      = r_peak_bin;
  assign bus.peak_mag      = r_peak_mag;

endmodule
